// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: two requester channels, result channel and response counter
interface fp16_mul_arbiter_if #(parameter int TAG_W = 4);
  logic             req0_valid, req0_ready;
  logic [15:0]      req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [15:0]      req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid, rsp_ready;
  logic [15:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      op_count;
  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_tag, op_count
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_tag, op_count
  );
endinterface

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one FP16 multiplier between two requesters
module fp16_mul_arbiter #(parameter int TAG_W = 4) (
  input logic              clk,
  input logic              rst_n,
  fp16_mul_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state, state_nx;
  logic             last_grant, gnt, slot_free, xfer, rsp_xfer, rsp_id_q;
  logic [15:0]      op_a, op_b, prod, rsp_data_q, op_count_q;
  logic [TAG_W-1:0] op_tag, rsp_tag_q;

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    logic [4:0] ea, eb, xa, xb, lz;
    logic [9:0] ma, mb;
    logic [10:0] sa, sb;
    logic [21:0] p, pn, pr;
    logic [43:0] ext;
    logic signed [7:0] e;
    logic [7:0] sh;
    logic up;
    logic [14:0] r;
    s = a[15] ^ b[15];
    ea = a[14:10];
    eb = b[14:10];
    ma = a[9:0];
    mb = b[9:0];
    sa = {ea != 5'd0, ma};
    sb = {eb != 5'd0, mb};
    xa = (ea == 5'd0) ? 5'd1 : ea;
    xb = (eb == 5'd0) ? 5'd1 : eb;
    p = 22'(sa) * 22'(sb);
    lz = 5'd0;
    for (int i = 0; i < 22; i++) if (p[i]) lz = 5'(21 - i);
    pn = p << lz;
    e = $signed({3'b0, xa}) + $signed({3'b0, xb}) - 8'sd14 - $signed({3'b0, lz});
    sh = (e < 8'sd1) ? 8'(8'sd1 - e) : 8'd0;
    ext = {pn, 22'b0} >> sh;
    pr = ext[43:22];
    up = pr[10] & (pr[11] | (|pr[9:0]) | (|ext[21:0]));
    // hidden bit is added on top of exponent-1 so rounding carries and subnormals fall out naturally
    r = 15'({(e < 8'sd1) ? 5'd0 : 5'(e[4:0] - 5'd1), 10'd0}) + 15'(pr[21:11]) + 15'(up);
    if ((ea == 5'h1f && ma != 10'd0) || (eb == 5'h1f && mb != 10'd0)) return 16'h7e00;
    if ((ea == 5'h1f && b[14:0] == 15'd0) || (eb == 5'h1f && a[14:0] == 15'd0)) return 16'h7e00;
    if (ea == 5'h1f || eb == 5'h1f || (p != 22'd0 && e > 8'sd30)) return {s, 15'h7c00};
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
    return {s, r};
  endfunction

  always_comb begin
    slot_free = (state == EMPTY) | bus.rsp_ready;
    gnt = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    xfer = rst_n & slot_free & (bus.req0_valid | bus.req1_valid);
    rsp_xfer = (state == FULL) & bus.rsp_ready;
    state_nx = xfer ? FULL : rsp_xfer ? EMPTY : state;
    op_a = gnt ? bus.req1_a : bus.req0_a;
    op_b = gnt ? bus.req1_b : bus.req0_b;
    op_tag = gnt ? bus.req1_tag : bus.req0_tag;
    prod = fp16_mul(op_a, op_b);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= 1'b1;
      rsp_data_q <= '0;
      rsp_id_q <= 1'b0;
      rsp_tag_q <= '0;
      op_count_q <= '0;
    end else begin
      if (xfer) begin
        last_grant <= gnt;
        rsp_data_q <= prod;
        rsp_id_q <= gnt;
        rsp_tag_q <= op_tag;
      end
      if (rsp_xfer) op_count_q <= op_count_q + 16'd1;
    end

  assign bus.req0_ready = xfer & ~gnt;
  assign bus.req1_ready = xfer & gnt;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_tag = rsp_tag_q;
  assign bus.op_count = op_count_q;
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed checks of arbitration, backpressure, products, wrap and reset
module tb_fp16_mul_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fp16_mul_arbiter_if #(.TAG_W(4)) bus();
  fp16_mul_arbiter #(.TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    bus.req1_valid = 1'b1;
    bus.req1_a = a;
    bus.req1_b = b;
    bus.req1_tag = 4'ha;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    check(tag, bus.rsp_data, exp);
    check({tag, "_id"}, bus.rsp_id, 1);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
    bus.rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #2;
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_count", bus.op_count, 0);
    check("rst_ready0", bus.req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_a = 16'h3c00; bus.req0_b = 16'h4000; bus.req0_tag = 4'd5;
    #1 check("single_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    check("single_valid", bus.rsp_valid, 1);
    check("single_data", bus.rsp_data, 16'h4000);
    check("single_id", bus.rsp_id, 0);
    check("single_tag", bus.rsp_tag, 5);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4400; bus.req0_b = 16'h3800; bus.req0_tag = 4'd7;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4200; bus.req1_b = 16'hc000; bus.req1_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", bus.req0_ready, 0);
      check("bp_ready1", bus.req1_ready, 0);
      check("bp_data", bus.rsp_data, 16'h4000);
      check("bp_tag", bus.rsp_tag, 5);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("refill_ready1", bus.req1_ready, 1);
    check("refill_ready0", bus.req0_ready, 0);
    tick();
    check("prod_data", bus.rsp_data, 16'hc600);
    check("prod_id", bus.rsp_id, 1);
    check("prod_tag", bus.rsp_tag, 3);
    check("prod_count", bus.op_count, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_valid", bus.rsp_valid, 1);
      check("rr_id", bus.rsp_id, i % 2);
      check("rr_data", bus.rsp_data, (i % 2) ? 16'hc600 : 16'h4000);
      check("rr_count", bus.op_count, 2 + i);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    check("drain_valid", bus.rsp_valid, 0);
    check("drain_count", bus.op_count, 6);
    single("inf", 16'h7c00, 16'h3c00, 16'h7c00);
    single("inf_x_zero", 16'h7c00, 16'h0000, 16'h7e00);
    single("subnormal", 16'h0001, 16'h3c00, 16'h0001);
    single("nan", 16'h7e00, 16'h3c00, 16'h7e00);
    single("neg_zero", 16'h8000, 16'h3c00, 16'h8000);
    single("overflow", 16'h7bff, 16'h4000, 16'h7c00);
    bus.req0_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    begin
      int n = 0;
      while (bus.op_count != 16'hffff && n < 70000) begin
        tick();
        n++;
      end
    end
    check("wrap_pre", bus.op_count, 16'hffff);
    tick();
    check("wrap", bus.op_count, 16'h0000);
    bus.rsp_ready = 1'b0;
    tick();
    check("hold_valid", bus.rsp_valid, 1);
    bus.req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bus.rsp_valid, 0);
    check("async_data", bus.rsp_data, 0);
    check("async_count", bus.op_count, 0);
    check("async_ready0", bus.req0_ready, 0);
    check("async_ready1", bus.req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 check("post_ready0", bus.req0_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rr_id", bus.rsp_id, i % 2);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
